// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the wait-state counter width.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, store merge, load extension.
// Optional: define DMEM_ALIGN_CHECK_EN to flag misaligned half/word accesses.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data,
  output logic        align_err
);

  logic [1:0]  lane;
  logic [31:0] wsh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Misaligned low bits are dropped here; the error flag decides whether that matters.
  always_comb begin
    lane = 2'b00;
    be   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        lane = addr_lo;
        be   = 4'b0001 << addr_lo;
      end
      2'b01: begin
        lane = {addr_lo[1], 1'b0};
        be   = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign wsh = wdata << {lane, 3'b000};

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign wr_word[8*gi +: 8] = be[gi] ? wsh[8*gi +: 8] : rd_word[8*gi +: 8];
  end

  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = rd_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the MEM stage: valid/ready request and response channels,
// programmable wait states, commit on the edge that enters RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] cnt_reg, cnt_next;
  logic              we_reg, we_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [2:0]        f3_reg, f3_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic              err_reg, err_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic              op_we;
  logic [31:0]       op_addr, op_wdata;
  logic [2:0]        op_f3;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       rd_word, wr_word, ld_data;
  logic [3:0]        be;
  logic              align_err, range_err, f3_err, op_err, commit, mem_we;

  // With zero wait states the commit edge is the accept edge, so use the live request.
  assign op_we    = (state_reg == IDLE) ? req_we     : we_reg;
  assign op_addr  = (state_reg == IDLE) ? req_addr   : addr_reg;
  assign op_wdata = (state_reg == IDLE) ? req_wdata  : wdata_reg;
  assign op_f3    = (state_reg == IDLE) ? req_funct3 : f3_reg;

  assign idx     = op_addr[IDX_W+1:2];
  assign rd_word = mem[idx];

  dmem_lane_align u_lane (
    .funct3    (op_f3),
    .addr_lo   (op_addr[1:0]),
    .rd_word   (rd_word),
    .wdata     (op_wdata),
    .be        (be),
    .wr_word   (wr_word),
    .ld_data   (ld_data),
    .align_err (align_err)
  );

  assign range_err = {2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign f3_err    = op_we ? (op_f3 > F3_W)
                           : ((op_f3[1:0] == 2'b11) || (op_f3 == 3'b110));
  assign op_err    = range_err || f3_err || align_err;

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    f3_next    = f3_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          we_next    = req_we;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          f3_next    = req_funct3;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            cnt_next   = WAIT_W'(WAIT_CYCLES - 1);
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - WAIT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (commit) begin
      rdata_next = (op_err || op_we) ? 32'h0 : ld_data;
      err_next   = op_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      f3_reg    <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      f3_reg    <= f3_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  // Array is never cleared; a write needs reset released so an accept under reset cannot commit.
  assign mem_we = rst && commit && op_we && !op_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states), directed table,
// reset corner sequences and random traffic against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        tb_rst     [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(gi == 0 ? 2 : 0)) u_dut (
      .clk        (clk),
      .rst        (tb_rst[gi]),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_we     (req_we[gi]),
      .req_addr   (req_addr[gi]),
      .req_wdata  (req_wdata[gi]),
      .req_funct3 (req_funct3[gi]),
      .rsp_valid  (rsp_valid[gi]),
      .rsp_ready  (rsp_ready[gi]),
      .rsp_rdata  (rsp_rdata[gi]),
      .rsp_err    (rsp_err[gi])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mref [2][4*DEPTH];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int lat_exp(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  // Reference: memory as a flat byte array, accesses as size-aligned byte runs.
  task automatic model(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int sz;
    int base;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    rd = 32'h0;
    er = we ? (f3 > 3'd2) : ((f3[1:0] == 2'b11) || (f3 == 3'b110));
    if (a / 4 >= DEPTH) er = 1'b1;
    if (ALIGN && (a % sz != 0)) er = 1'b1;
    if (er) return;
    base = int'(a - (a % sz));
    if (we) begin
      for (int i = 0; i < sz; i++) mref[d][base+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(mref[d][base+i]) << (8*i));
      if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
      if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
      rd = v;
    end
  endtask

  task automatic tx(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                    input logic [2:0] f3, input int hold, output logic [31:0] rd, output logic er);
    int n;
    rd = 32'h0;
    er = 1'b0;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = wd; req_funct3[d] = f3;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      chk("req_ready_timeout", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble the request fields after capture; the responder must ignore them.
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_addr[d] = $urandom;
    req_wdata[d] = $urandom; req_funct3[d] = 3'($urandom);
    n = 1;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", n, lat_exp(d));
    if (rsp_valid[d] !== 1'b1) return;
    rd = rsp_rdata[d];
    er = rsp_err[d];
    chk("req_ready_in_resp", 32'(req_ready[d]), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], rd);
      chk("hold_err", 32'(rsp_err[d]), 32'(er));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("valid_drop", 32'(rsp_valid[d]), 32'd0);
    chk("req_ready_back", 32'(req_ready[d]), 32'd1);
    $display("tx d=%0d we=%0b addr=%h wdata=%h f3=%0d hold=%0d rdata=%h err=%0b",
             d, we, a, wd, f3, hold, rd, er);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got_rd, exp_rd, wd, a;
    logic        got_er, exp_er, we;
    logic [2:0]  f3;
    int          n;

    for (int d = 0; d < 2; d++) begin
      tb_rst[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; req_we[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; req_funct3[d] = '0;
    end

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 3'd2, 0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        3'd2, 5, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h13,  32'h0,        3'd0, 0, 32'hFFFFFFDE, 1'b0};
    tbl[3]  = '{1'b0, 32'h13,  32'h0,        3'd4, 1, 32'h000000DE, 1'b0};
    tbl[4]  = '{1'b0, 32'h12,  32'h0,        3'd1, 0, 32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{1'b0, 32'h10,  32'h0,        3'd5, 0, 32'h0000BEEF, 1'b0};
    tbl[6]  = '{1'b1, 32'h11,  32'h55,       3'd0, 0, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 32'h10,  32'h0,        3'd2, 0, 32'hDEAD55EF, 1'b0};
    tbl[8]  = '{1'b0, 32'h400, 32'h0,        3'd2, 2, 32'h0,        1'b1};
    tbl[9]  = '{1'b0, 32'h10,  32'h0,        3'd3, 0, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 32'h11,  32'h0,        3'd2, 0, ALIGN ? 32'h0 : 32'hDEAD55EF, ALIGN};
    tbl[11] = '{1'b1, 32'h10,  32'hFFFFFFFF, 3'd4, 0, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 32'h10,  32'h0,        3'd2, 0, 32'hDEAD55EF, 1'b0};
    tbl[13] = '{1'b1, 32'h12,  32'hA5A51234, 3'd1, 0, 32'h0,        1'b0};
    tbl[14] = '{1'b0, 32'h10,  32'h0,        3'd2, 0, 32'h123455EF, 1'b0};
    tbl[15] = '{1'b0, 32'h11,  32'h0,        3'd0, 0, 32'h00000055, 1'b0};
    tbl[16] = '{1'b0, 32'h10,  32'h0,        3'd6, 0, 32'h0,        1'b1};
    tbl[17] = '{1'b1, 32'h3FC, 32'h0BADF00D, 3'd2, 0, 32'h0,        1'b0};
    tbl[18] = '{1'b0, 32'h3FC, 32'h0,        3'd2, 0, 32'h0BADF00D, 1'b0};

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[d], 32'h0);
      chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    tb_rst[0] = 1'b1; tb_rst[1] = 1'b1;
    @(posedge clk); #1;

    // Give the low region known contents in both instances.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 32; w++) begin
        wd = $urandom;
        model(d, 1'b1, 32'(4*w), wd, 3'd2, exp_rd, exp_er);
        tx(d, 1'b1, 32'(4*w), wd, 3'd2, 0, got_rd, got_er);
        chk("init_err", 32'(got_er), 32'd0);
      end
    end

    // Directed table on the wait-state instance.
    for (int i = 0; i < 19; i++) begin
      model(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, exp_rd, exp_er);
      tx(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, tbl[i].hold, got_rd, got_er);
      chk($sformatf("tbl%0d_rdata", i), got_rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(got_er), 32'(tbl[i].exp_err));
    end

    // Reset during ACCESS aborts the store.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h12345678; req_funct3[0] = 3'd2;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("abort_in_access", 32'(rsp_valid[0]), 32'd0);
    tb_rst[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
    end
    chk("abort_rsp_rdata", rsp_rdata[0], 32'h0);
    tb_rst[0] = 1'b1;
    @(posedge clk); #1;
    model(0, 1'b0, 32'h20, 32'h0, 3'd2, exp_rd, exp_er);
    tx(0, 1'b0, 32'h20, 32'h0, 3'd2, 0, got_rd, got_er);
    chk("abort_old_data", got_rd, exp_rd);

    // Reset during RESP drops the response but keeps the committed store.
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h24;
    req_wdata[1] = 32'hCAFEF00D; req_funct3[1] = 3'd2;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("resp_before_rst", 32'(rsp_valid[1]), 32'd1);
    tb_rst[1] = 1'b0;
    #1;
    chk("resp_rst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("resp_rst_rdata", rsp_rdata[1], 32'h0);
    @(posedge clk); #1;
    tb_rst[1] = 1'b1;
    @(posedge clk); #1;
    model(1, 1'b1, 32'h24, 32'hCAFEF00D, 3'd2, exp_rd, exp_er);
    tx(1, 1'b0, 32'h24, 32'h0, 3'd2, 0, got_rd, got_er);
    chk("resp_rst_kept", got_rd, 32'hCAFEF00D);

    // Random traffic against the model on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 150; k++) begin
        we = 1'($urandom);
        f3 = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) begin
          a = $urandom;
          if (a < 32'h400) a = a + 32'h400;
        end else begin
          a = 32'($urandom_range(0, 127));
        end
        wd = $urandom;
        n = $urandom_range(0, 2);
        model(d, we, a, wd, f3, exp_rd, exp_er);
        tx(d, we, a, wd, f3, n, got_rd, got_er);
        chk("rand_rdata", got_rd, exp_rd);
        chk("rand_err", 32'(got_er), 32'(exp_er));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory target for the pipelined RV32I core's MEM stage.
- Serves byte, half and word loads and stores over a valid/ready request channel and a valid/ready response channel.
- Has a programmable wait-state latency, so the pipeline's stall logic can be exercised against a non-ideal memory.
- Includes RV32I load extension and store byte-lane merge.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words. Legal byte addresses are 0 to 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: extra cycles spent in ACCESS before the response. Legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_funct3  in  3  RV32I funct3 access size and sign.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access faulted; no memory side effect occurred.

Behaviour:
- Reset values while rst=0: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. The memory array is not cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture we, addr, wdata and funct3.
  - If WAIT_CYCLES=0, go directly to RESP; otherwise load the counter with WAIT_CYCLES-1 and go to ACCESS.
- ACCESS:
  - req_ready=0.
  - Decrement the counter each cycle; at 0, go to RESP.
- Commit point: the array read or write happens on the edge that enters RESP. Stores are therefore committed exactly once.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1, go to IDLE; rsp_valid drops the next cycle.
  - No back-to-back overlap: req_ready=0 during RESP. A new request is accepted at the earliest one cycle after the response handshake.
- Latency: request accept to rsp_valid is WAIT_CYCLES+1 cycles.
- Load funct3 decoding:
  - 000 lb: sign-extend the addressed byte.
  - 001 lh: sign-extend the addressed half.
  - 010 lw: full word.
  - 100 lbu, 101 lhu: zero-extend.
- Byte lane selection: taken from addr[1:0]. Halves use addr[1].
- Store funct3 decoding:
  - 000 sb, 001 sh, 010 sw.
  - Only the enabled byte lanes are written; the other bytes of the word are preserved.
- Error conditions (rsp_err=1, rsp_rdata=0, no write):
  - Word index addr[31:2] >= DEPTH_WORDS.
  - Illegal funct3: 011, 110 or 111 for loads; anything other than 000/001/010 for stores.
  - Misalignment (see Optional Feature).
- req_* inputs are ignored outside the IDLE handshake. Changes to them after capture have no effect.
- Reset mid-operation: asserting rst in ACCESS aborts the transaction with no write. Asserting rst in RESP drops the pending response; the already-committed store remains.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, returns rsp_err=1 with no side effect.
- Undefined: misaligned low address bits are forced to zero before lane selection (half uses addr[1] only; word ignores addr[1:0]), and no error is raised.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state encoding IDLE, ACCESS, RESP;
  - the WAIT counter width constant (4).
- Sub-module dmem_lane_align (combinational) takes funct3, addr[1:0], the stored word and the write data. It outputs:
  - the 4-bit byte-enable;
  - the merged write word;
  - the extended load result;
  - the alignment-error flag.
- The top module keeps the FSM, counter, capture registers, array and range check.

Test Plan:
- Reset, then sw addr=0x10 data=0xDEADBEEF, then lw 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid rises exactly 3 cycles after accept (WAIT_CYCLES=2).
- After the store above: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
- sb 0x11 data=0x55, then lw 0x10 -> 0xDEAD55EF; neighbouring bytes are preserved.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_rdata is stable and req_ready=0. Release -> IDLE and req_ready=1 the next cycle.
- Errors:
  - lw addr=4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0.
  - Load with funct3=011 -> rsp_err=1.
  - With DMEM_ALIGN_CHECK_EN defined: lw 0x11 -> rsp_err=1.
  - Without it: lw 0x11 -> returns the word at 0x10.
- Assert rst during ACCESS of sw 0x20 data=0x12345678, then lw 0x20 -> old contents; rsp_valid=0 during reset. Repeat with WAIT_CYCLES=0 -> response 1 cycle after accept.
